// File: rtl/vm_pkg.sv
// Shared vending-machine definitions: coin values, one-hot coin codes,
// coin-acceptor state encoding and the credit width.
package vm_pkg;

   localparam int unsigned MONEY_W = 12;
   localparam int unsigned COIN_W  = 5;
   localparam int unsigned SUM_W   = MONEY_W + 1;

   localparam logic [MONEY_W-1:0] VAL_NICKEL      = MONEY_W'(5);
   localparam logic [MONEY_W-1:0] VAL_DIME        = MONEY_W'(10);
   localparam logic [MONEY_W-1:0] VAL_QUARTER     = MONEY_W'(25);
   localparam logic [MONEY_W-1:0] VAL_HALF_DOLLAR = MONEY_W'(50);
   localparam logic [MONEY_W-1:0] VAL_DOLLAR      = MONEY_W'(100);

   // Bit position in the sensor vector equals coin rank, nickel at bit 0.
   typedef enum logic [COIN_W-1:0] {
      COIN_NONE        = 5'b00000,
      COIN_NICKEL      = 5'b00001,
      COIN_DIME        = 5'b00010,
      COIN_QUARTER     = 5'b00100,
      COIN_HALF_DOLLAR = 5'b01000,
      COIN_DOLLAR      = 5'b10000
   } coin_e;

   typedef enum logic [2:0] {
      IDLE,
      QUALIFY,
      CREDIT,
      REJECT,
      RELEASE
   } acc_state_e;

   typedef struct packed {
      logic [COIN_W-1:0] pulse;
      logic              reject;
   } acc_out_t;

   function automatic logic [MONEY_W-1:0] coin_value(input logic [COIN_W-1:0] code);
      case (code)
         COIN_NICKEL:      coin_value = VAL_NICKEL;
         COIN_DIME:        coin_value = VAL_DIME;
         COIN_QUARTER:     coin_value = VAL_QUARTER;
         COIN_HALF_DOLLAR: coin_value = VAL_HALF_DOLLAR;
         COIN_DOLLAR:      coin_value = VAL_DOLLAR;
         default:          coin_value = '0;
      endcase
   endfunction

endpackage

// File: rtl/vm_coin_acceptor_if.sv
// Sensor, control and result signals of the coin acceptor.
// coin_jam is present only when VM_COIN_JAM_DETECT_EN is defined.
interface vm_coin_acceptor_if;

   logic                         sense_nickel;
   logic                         sense_dime;
   logic                         sense_quarter;
   logic                         sense_half_dollar;
   logic                         sense_dollar;
   logic                         accept_en;
   logic                         clear_total;
   logic                         nickel;
   logic                         dime;
   logic                         quarter;
   logic                         half_dollar;
   logic                         dollar;
   logic [vm_pkg::MONEY_W-1:0]   total_money;
   logic                         coin_reject;
   logic                         busy;
`ifdef VM_COIN_JAM_DETECT_EN
   logic                         coin_jam;

   modport slave (
      input  sense_nickel, sense_dime, sense_quarter, sense_half_dollar, sense_dollar,
      input  accept_en, clear_total,
      output nickel, dime, quarter, half_dollar, dollar,
      output total_money, coin_reject, busy, coin_jam
   );

   modport master (
      output sense_nickel, sense_dime, sense_quarter, sense_half_dollar, sense_dollar,
      output accept_en, clear_total,
      input  nickel, dime, quarter, half_dollar, dollar,
      input  total_money, coin_reject, busy, coin_jam
   );
`else
   modport slave (
      input  sense_nickel, sense_dime, sense_quarter, sense_half_dollar, sense_dollar,
      input  accept_en, clear_total,
      output nickel, dime, quarter, half_dollar, dollar,
      output total_money, coin_reject, busy
   );

   modport master (
      output sense_nickel, sense_dime, sense_quarter, sense_half_dollar, sense_dollar,
      output accept_en, clear_total,
      input  nickel, dime, quarter, half_dollar, dollar,
      input  total_money, coin_reject, busy
   );
`endif

endinterface

// File: rtl/vm_sync2.sv
// Parameterized-width two-flop synchronizer with asynchronous active-high reset.
module vm_sync2 #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/vm_coin_acceptor.sv
// Coin acceptor: synchronizes and debounces five coin sensors, credits or rejects
// each insertion and tracks total credit. VM_COIN_JAM_DETECT_EN adds stuck-sensor detection.
module vm_coin_acceptor
   import vm_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned MAX_CREDIT      = 1000
) (
   input  logic               clk,
   input  logic               reset,
   vm_coin_acceptor_if.slave  bus
);

   localparam int unsigned       CNT_W   = 8;
   localparam logic [CNT_W-1:0]  DEB     = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [SUM_W-1:0]  MAX_SUM = SUM_W'(MAX_CREDIT);

   logic [COIN_W-1:0]  sense_raw;
   logic [COIN_W-1:0]  s;
   acc_state_e         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [COIN_W-1:0]  code_q, code_d;
   acc_out_t           out_q, out_d;
   logic               busy_q, busy_d;
   logic [MONEY_W-1:0] total_q, total_d;
   logic [SUM_W-1:0]   credit_sum;
   logic               over_limit;
   logic               single_coin;

   assign sense_raw = {bus.sense_dollar, bus.sense_half_dollar, bus.sense_quarter,
                       bus.sense_dime, bus.sense_nickel};

   vm_sync2 #(.WIDTH(COIN_W)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d_i   (sense_raw),
      .q_o   (s)
   );

   // Limit check uses the credit before this edge's clear, so wrap-around cannot occur.
   assign credit_sum  = {1'b0, total_q} + {1'b0, coin_value(code_q)};
   assign over_limit  = (credit_sum > MAX_SUM);
   assign single_coin = (s != '0) && ((s & (s - COIN_W'(1))) == '0);

`ifdef VM_COIN_JAM_DETECT_EN
   localparam logic [CNT_W-1:0] JAM_LIMIT = CNT_W'(255);
   logic             jam_q, jam_d;
   logic [CNT_W-1:0] jcnt_q, jcnt_d;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         code_q  <= '0;
         out_q   <= '0;
         busy_q  <= 1'b0;
         total_q <= '0;
`ifdef VM_COIN_JAM_DETECT_EN
         jam_q   <= 1'b0;
         jcnt_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         code_q  <= code_d;
         out_q   <= out_d;
         busy_q  <= busy_d;
         total_q <= total_d;
`ifdef VM_COIN_JAM_DETECT_EN
         jam_q   <= jam_d;
         jcnt_q  <= jcnt_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      code_d  = code_q;
      out_d   = '0;
      total_d = bus.clear_total ? '0 : total_q;
`ifdef VM_COIN_JAM_DETECT_EN
      jam_d   = jam_q;
      jcnt_d  = jcnt_q;
`endif
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (single_coin) begin
               state_d = QUALIFY;
               cnt_d   = CNT_W'(1);
               code_d  = s;
            end else if (s != '0) begin
               state_d      = REJECT;
               out_d.reject = 1'b1;
            end
         end
         QUALIFY: begin
            // Evaluation happens on the edge after the count reaches the debounce length.
            if (s == code_q) begin
               if (cnt_q >= DEB) begin
                  if (!bus.accept_en || over_limit) begin
                     state_d      = REJECT;
                     out_d.reject = 1'b1;
                  end else begin
                     state_d     = CREDIT;
                     out_d.pulse = code_q;
                     total_d     = total_d + coin_value(code_q);
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end else if (s == '0) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               state_d      = REJECT;
               out_d.reject = 1'b1;
            end
         end
         CREDIT, REJECT: begin
            state_d = RELEASE;
            cnt_d   = '0;
`ifdef VM_COIN_JAM_DETECT_EN
            jcnt_d  = '0;
`endif
         end
         RELEASE: begin
            if (s == '0) begin
               if (cnt_q + CNT_W'(1) >= DEB) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end else begin
               cnt_d = '0;
            end
`ifdef VM_COIN_JAM_DETECT_EN
            // 256th consecutive nonzero cycle sets the sticky jam; a jam pins the FSM here.
            if (s == '0) begin
               jcnt_d = '0;
            end else if (jcnt_q == JAM_LIMIT) begin
               jam_d = 1'b1;
            end else begin
               jcnt_d = jcnt_q + CNT_W'(1);
            end
            if (jam_q) begin
               state_d = RELEASE;
               cnt_d   = '0;
            end
`endif
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   assign bus.nickel      = out_q.pulse[0];
   assign bus.dime        = out_q.pulse[1];
   assign bus.quarter     = out_q.pulse[2];
   assign bus.half_dollar = out_q.pulse[3];
   assign bus.dollar      = out_q.pulse[4];
   assign bus.coin_reject = out_q.reject;
   assign bus.busy        = busy_q;
   assign bus.total_money = total_q;
`ifdef VM_COIN_JAM_DETECT_EN
   assign bus.coin_jam    = jam_q;
`endif

endmodule
